// File: rtl/keypoint_collect.sv
// keypoint_collect
//   Turns the extremum stage's per-pixel key_valid/key_mark stream into
//   {row, col} keypoint coordinates in original-image space, buffers them in
//   a FIFO and streams them out on an AXI-stream master. After each frame a
//   trailer word {drop_cnt, key_cnt} follows the last keypoint of that frame.
//
// Ports
//   axi_clk        clock
//   axi_rst        asynchronous, active-high reset
//   key_valid      one pulse per pixel position
//   key_mark       pixel is an extremum (qualified by key_valid)
//   m_axis_tdata   keypoint {row, col} or trailer {drop_cnt, key_cnt}
//   m_axis_tvalid  output word valid
//   m_axis_tready  downstream ready
//   m_axis_tuser   1 = trailer word
//   m_axis_tlast   1 = trailer word (end of frame)
//   overflow       sticky: a keypoint or trailer was lost

module keypoint_collect #(
    parameter int KEY_COLUMN   = 508,
    parameter int KEY_ROW      = 508,
    parameter int COORD_OFFSET = 2,
    parameter int COORD_WIDTH  = 16,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic                     axi_clk,
    input  logic                     axi_rst,
    input  logic                     key_valid,
    input  logic                     key_mark,
    output logic [2*COORD_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     overflow
);

    localparam int CW = (KEY_COLUMN > 1) ? $clog2(KEY_COLUMN) : 1;
    localparam int RW = (KEY_ROW > 1) ? $clog2(KEY_ROW) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW = 2 * COORD_WIDTH;

    logic [CW-1:0]          col_cnt;
    logic [RW-1:0]          row_cnt;
    logic                   col_last;
    logic                   row_last;
    logic                   frame_end;

    logic [DW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic [AW:0]            count_next;
    logic                   fifo_full;

    logic [COORD_WIDTH-1:0] key_cnt;
    logic [COORD_WIDTH-1:0] drop_cnt;
    logic [COORD_WIDTH-1:0] key_snap;
    logic [COORD_WIDTH-1:0] drop_snap;
    logic [COORD_WIDTH-1:0] trl_key;
    logic [COORD_WIDTH-1:0] trl_drop;
    logic                   trailer_pending;
    logic [AW:0]            remain;

    logic                   wr_req;
    logic                   wr_ok;
    logic                   drop;
    logic                   trailer_sel;
    logic                   xfer;
    logic                   pop;
    logic                   trailer_xfer;
    logic                   capture;
    logic [COORD_WIDTH-1:0] row_coord;
    logic [COORD_WIDTH-1:0] col_coord;

    assign col_last  = (col_cnt == CW'(KEY_COLUMN - 1));
    assign row_last  = (row_cnt == RW'(KEY_ROW - 1));
    assign frame_end = key_valid && col_last && row_last;

    assign row_coord = COORD_WIDTH'(row_cnt) + COORD_WIDTH'(COORD_OFFSET);
    assign col_coord = COORD_WIDTH'(col_cnt) + COORD_WIDTH'(COORD_OFFSET);

    // Occupancy is judged before this cycle's pop, so a full FIFO drops the
    // incoming keypoint even if the head leaves in the same cycle.
    assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
    assign wr_req    = key_valid && key_mark;
    assign wr_ok     = wr_req && !fifo_full;
    assign drop      = wr_req && fifo_full;

    // The trailer is shown only once every entry queued ahead of it is gone;
    // later-frame keypoints sit behind it in the FIFO.
    assign trailer_sel   = trailer_pending && (remain == '0);
    assign m_axis_tvalid = (count != '0) || trailer_sel;
    assign m_axis_tuser  = trailer_sel;
    assign m_axis_tlast  = trailer_sel;
    assign m_axis_tdata  = !m_axis_tvalid ? '0 :
                           trailer_sel    ? {trl_drop, trl_key} : mem[rd_ptr];

    assign xfer         = m_axis_tvalid && m_axis_tready;
    assign pop          = xfer && !trailer_sel;
    assign trailer_xfer = xfer && trailer_sel;

    // A new trailer can only be captured if the slot is free or being freed.
    assign capture = frame_end && (!trailer_pending || trailer_xfer);

    assign key_snap  = (wr_ok && key_cnt != '1)  ? key_cnt + COORD_WIDTH'(1)  : key_cnt;
    assign drop_snap = (drop && drop_cnt != '1) ? drop_cnt + COORD_WIDTH'(1) : drop_cnt;

    always_comb begin
        count_next = count;
        if (wr_ok && !pop) begin
            count_next = count + (AW+1)'(1);
        end else if (!wr_ok && pop) begin
            count_next = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (key_valid) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    // Storage array carries no reset; tdata is forced to zero whenever
    // nothing valid is presented.
    always_ff @(posedge axi_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {row_coord, col_coord};
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            key_cnt         <= '0;
            drop_cnt        <= '0;
            trl_key         <= '0;
            trl_drop        <= '0;
            trailer_pending <= 1'b0;
            remain          <= '0;
            overflow        <= 1'b0;
        end else begin
            if (frame_end) begin
                key_cnt  <= '0;
                drop_cnt <= '0;
            end else begin
                key_cnt  <= key_snap;
                drop_cnt <= drop_snap;
            end

            if (capture) begin
                trl_key         <= key_snap;
                trl_drop        <= drop_snap;
                trailer_pending <= 1'b1;
                remain          <= count_next;
            end else begin
                if (trailer_xfer) begin
                    trailer_pending <= 1'b0;
                end
                if (pop && remain != '0) begin
                    remain <= remain - (AW+1)'(1);
                end
            end

            if (drop || (frame_end && !capture)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypoint_collect.sv
module tb_keypoint_collect;

    localparam int KC = 4;
    localparam int KR = 3;
    localparam int NPIX = KC * KR;

    logic        axi_clk = 1'b0;
    logic        axi_rst = 1'b1;
    logic        key_valid = 1'b0;
    logic        key_mark = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [33:0] q[$];
    logic [33:0] exp_word;
    logic [33:0] obs_word;
    logic        mon_en = 1'b0;

    keypoint_collect #(
        .KEY_COLUMN  (KC),
        .KEY_ROW     (KR),
        .COORD_OFFSET(2),
        .COORD_WIDTH (16),
        .FIFO_DEPTH  (4)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_rst      (axi_rst),
        .key_valid    (key_valid),
        .key_mark     (key_mark),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .overflow     (overflow)
    );

    always #5 axi_clk = ~axi_clk;

    // Scoreboard: every handshake pops the oldest expected word.
    always @(negedge axi_clk) begin
        if (mon_en && !axi_rst && m_axis_tvalid && m_axis_tready) begin
            obs_word = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL stream_unexpected got=%h (nothing expected)", obs_word);
            end else begin
                exp_word = q.pop_front();
                if (obs_word !== exp_word) begin
                    bad++;
                    $display("FAIL stream_word got=%h expected=%h", obs_word, exp_word);
                end
            end
        end
    end

    task automatic push_key(input logic [31:0] d);
        q.push_back({2'b00, d});
    endtask

    task automatic push_trl(input logic [15:0] drop, input logic [15:0] keys);
        q.push_back({2'b11, drop, keys});
    endtask

    task automatic pix(input logic mark);
        key_valid = 1'b1;
        key_mark  = mark;
        @(posedge axi_clk);
        #1;
        key_valid = 1'b0;
        key_mark  = 1'b0;
    endtask

    task automatic frame(input logic [NPIX-1:0] mask);
        for (int i = 0; i < NPIX; i++) pix(mask[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        axi_rst = 1'b1;
        q.delete();
        @(posedge axi_clk);
        #1;
        axi_rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge axi_clk);
            #1;
            n++;
        end
        idle(2);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain left=%0d expected=0", name, q.size());
        end
        total++;
        if (m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle tvalid=%b expected=0", name, m_axis_tvalid);
        end
    endtask

    task automatic test_reset();
        axi_rst = 1'b1;
        #12;
        total += 5;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b expected=0", m_axis_tvalid); end
        if (m_axis_tuser !== 1'b0)  begin bad++; $display("FAIL reset_tuser got=%b expected=0", m_axis_tuser); end
        if (m_axis_tlast !== 1'b0)  begin bad++; $display("FAIL reset_tlast got=%b expected=0", m_axis_tlast); end
        if (m_axis_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata got=%h expected=0", m_axis_tdata); end
        if (overflow !== 1'b0)      begin bad++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
        @(posedge axi_clk);
        #1;
        axi_rst = 1'b0;
        mon_en  = 1'b1;
    endtask

    task automatic test_basic();
        m_axis_tready = 1'b1;
        push_key(32'h0002_0003);
        push_key(32'h0004_0005);
        push_trl(16'd0, 16'd2);
        pix(1'b0);
        pix(1'b1);
        total += 2;
        if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL basic_latency tvalid=%b expected=1", m_axis_tvalid); end
        if (m_axis_tdata !== 32'h0002_0003) begin bad++; $display("FAIL basic_head tdata=%h expected=00020003", m_axis_tdata); end
        for (int i = 2; i < NPIX; i++) pix(i == NPIX - 1);
        drain("basic");
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%b expected=0", overflow); end
    endtask

    task automatic test_backpressure();
        logic [NPIX-1:0] mask;
        mask = '0;
        mask[0]  = 1'b1;
        mask[6]  = 1'b1;
        mask[11] = 1'b1;
        m_axis_tready = 1'b0;
        push_key(32'h0002_0002);
        push_key(32'h0003_0004);
        push_key(32'h0004_0005);
        push_trl(16'd0, 16'd3);
        for (int i = 0; i < NPIX; i++) begin
            pix(mask[i]);
            total++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0002_0002 || m_axis_tuser !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold pix=%0d tvalid=%b tdata=%h tuser=%b expected 1/00020002/0",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tuser);
            end
        end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (m_axis_tvalid !== 1'b1) begin
                bad++;
                $display("FAIL bp_consecutive beat=%0d tvalid=%b expected=1", i, m_axis_tvalid);
            end
            @(posedge axi_clk);
            #1;
        end
        drain("backpressure");
    endtask

    task automatic test_last_pixel();
        logic [NPIX-1:0] mask;
        m_axis_tready = 1'b1;
        push_key(32'h0004_0005);
        push_trl(16'd0, 16'd1);
        push_key(32'h0002_0002);
        push_trl(16'd0, 16'd1);
        mask = '0;
        mask[NPIX-1] = 1'b1;
        frame(mask);
        mask = '0;
        mask[0] = 1'b1;
        frame(mask);
        drain("last_pixel");
    endtask

    task automatic test_overflow();
        m_axis_tready = 1'b0;
        push_key(32'h0002_0002);
        push_key(32'h0002_0003);
        push_key(32'h0002_0004);
        push_key(32'h0002_0005);
        push_trl(16'd8, 16'd4);
        frame('1);
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b expected=1", overflow); end
        m_axis_tready = 1'b1;
        drain("overflow");
    endtask

    task automatic test_double_frame();
        apply_reset();
        m_axis_tready = 1'b0;
        push_trl(16'd0, 16'd0);
        frame('0);
        total += 2;
        if (overflow !== 1'b0) begin bad++; $display("FAIL dbl_first_overflow got=%b expected=0", overflow); end
        if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 1'b1) begin
            bad++;
            $display("FAIL dbl_trailer_shown tvalid=%b tuser=%b expected 1/1", m_axis_tvalid, m_axis_tuser);
        end
        frame('0);
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL dbl_second_overflow got=%b expected=1", overflow); end
        m_axis_tready = 1'b1;
        drain("double_frame");
    endtask

    task automatic test_async_reset();
        apply_reset();
        m_axis_tready = 1'b0;
        pix(1'b1);
        pix(1'b1);
        total++;
        if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL arst_pre tvalid=%b expected=1", m_axis_tvalid); end
        #1;
        axi_rst = 1'b1;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL arst_immediate tvalid=%b expected=0", m_axis_tvalid); end
        q.delete();
        @(posedge axi_clk);
        #1;
        axi_rst = 1'b0;
        m_axis_tready = 1'b1;
        push_key(32'h0002_0002);
        pix(1'b1);
        drain("async_reset");
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL arst_overflow got=%b expected=0", overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_last_pixel();
        test_overflow();
        test_double_frame();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
